// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSD first, with a registered
// inter-digit carry and valid/ready handshakes on both sides.
module digit_serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int N    = WIDTH / DIGIT;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("digit_serial_add_sub: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic                   carry_q, carry_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [WIDTH-1:0]       sum_q, sum_d;
    logic                   cout_q, cout_d, ovf_q, ovf_d;
    logic [DIGIT-1:0]       dsum;
    logic [DIGIT:0]         c;
    logic [WIDTH+DIGIT-1:0] acc_shift;
    logic                   last;

    // One digit of full-adder ripple; c[DIGIT-1] is the carry into this digit's top bit.
    always_comb begin
        c    = '0;
        dsum = '0;
        c[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1]   = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    assign acc_shift = {dsum, acc_q} >> DIGIT;
    assign last      = (cnt_q == CNTW'(N - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b ^ {WIDTH{in_sub}};
                    carry_d = in_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift[WIDTH-1:0];
                carry_d = c[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    sum_d   = acc_shift[WIDTH-1:0];
                    cout_d  = c[DIGIT];
                    ovf_d   = c[DIGIT] ^ c[DIGIT-1];
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand and partial-result shifters are fully rewritten by every operation.
    always_ff @(posedge clock) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Directed and random checks of digit_serial_add_sub at DIGIT = 4, 1, 2, 8, 16 side by side.
module tb_digit_serial_add_sub;

    localparam int W  = 16;
    localparam int NI = 5;
    localparam int DG [NI] = '{4, 1, 2, 8, 16};

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid, out_ready, in_sub;
    logic [W-1:0] in_a, in_b;
    logic         in_ready [NI];
    logic         out_valid[NI];
    logic         out_cout [NI];
    logic         out_ovf  [NI];
    logic [W-1:0] out_sum  [NI];

    int           total = 0;
    int           bad   = 0;
    int           lat[NI];
    logic [W-1:0] rs [NI];
    logic         rc [NI];
    logic         ro [NI];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        digit_serial_add_sub #(.WIDTH(W), .DIGIT(DG[g])) u_dut (
            .clock    (clock),
            .reset    (reset),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .in_a     (in_a),
            .in_b     (in_b),
            .in_sub   (in_sub),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_sum  (out_sum[g]),
            .out_cout (out_cout[g]),
            .out_ovf  (out_ovf[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    localparam int NV = 7;
    localparam vec_t VEC [NV] = '{
        '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
        '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0}
    };

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W:0] r;
        logic       bs, ovf;
        r   = s ? ({1'b0, a} - {1'b0, b} + 17'h10000) : ({1'b0, a} + {1'b0, b});
        bs  = s ? ~b[W-1] : b[W-1];
        ovf = (a[W-1] == bs) && (r[W-1] != a[W-1]);
        return {ovf, r};
    endfunction

    // Launch one operation on all instances; the operand bus is scrambled right after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bit all_done;
        @(negedge clock);
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < NI; i++) lat[i] = 0;
        @(posedge clock); #1;
        in_valid = 1'b0; in_a = ~a; in_b = a ^ b; in_sub = ~s;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clock); #1;
            all_done = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (lat[i] == 0 && out_valid[i]) begin
                    lat[i] = cyc; rs[i] = out_sum[i]; rc[i] = out_cout[i]; ro[i] = out_ovf[i];
                end
                if (lat[i] == 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        @(posedge clock); #1;
    endtask

    task automatic check_op(input string nm, input logic [W-1:0] es, input logic ec,
                            input logic eo);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_lat_d%0d", nm, DG[i]), lat[i], W / DG[i]);
            chk($sformatf("%s_sum_d%0d", nm, DG[i]), rs[i], es);
            chk($sformatf("%s_cout_d%0d", nm, DG[i]), rc[i], ec);
            chk($sformatf("%s_ovf_d%0d", nm, DG[i]), ro[i], eo);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rsub;
        logic [W+1:0] m;
        int           n;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0;
        #12;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", out_valid[i], 0);
            chk("rst_ready", in_ready[i], 1);
            chk("rst_sum", out_sum[i], 0);
            chk("rst_cout", out_cout[i], 0);
            chk("rst_ovf", out_ovf[i], 0);
        end
        @(negedge clock); reset = 1'b1;

        for (int v = 0; v < NV; v++) begin
            run_op(VEC[v].a, VEC[v].b, VEC[v].s);
            check_op($sformatf("dir%0d", v), VEC[v].sum, VEC[v].cout, VEC[v].ovf);
        end

        // Backpressure on the DIGIT=4 instance, with ignored in_valid pulses in RUN and DONE.
        @(negedge clock);
        in_a = 16'h00F0; in_b = 16'h0F00; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1; in_valid = 1'b0;
        @(negedge clock); in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_sub = 1'b1;
        @(negedge clock); in_valid = 1'b0;
        n = 0;
        while (n < 20 && !out_valid[0]) begin
            @(posedge clock); #1; n++;
        end
        chk("bp_valid", out_valid[0], 1);
        for (int k = 0; k < 10; k++) begin
            in_valid = (k == 3 || k == 4);
            in_a = 16'h1111 * k[15:0]; in_b = 16'h2222;
            chk("bp_hold_sum", out_sum[0], 16'h0FF0);
            chk("bp_hold_valid", out_valid[0], 1);
            chk("bp_in_ready", in_ready[0], 0);
            chk("bp_hold_cout", out_cout[0], 0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock); out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_after_valid", out_valid[0], 0);
        chk("bp_after_ready", in_ready[0], 1);
        chk("bp_after_sum_hold", out_sum[0], 16'h0FF0);
        repeat (20) @(posedge clock);
        #1;
        chk("bp_no_extra_op", out_valid[0], 0);
        chk("bp_idle_d1", in_ready[1], 1);

        // Asynchronous reset two digits into an operation.
        @(negedge clock);
        in_a = 16'h1234; in_b = 16'h1111; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1; in_valid = 1'b0;
        @(posedge clock); @(posedge clock);
        #2; reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("mid_rst_valid_d%0d", DG[i]), out_valid[i], 0);
            chk($sformatf("mid_rst_ready_d%0d", DG[i]), in_ready[i], 1);
            chk($sformatf("mid_rst_sum_d%0d", DG[i]), out_sum[i], 0);
        end
        @(negedge clock); reset = 1'b1;
        run_op(16'h1234, 16'h1111, 1'b0);
        check_op("post_rst", 16'h2345, 1'b0, 1'b0);

        for (int r = 0; r < 1000; r++) begin
            ra = W'($urandom); rb = W'($urandom); rsub = 1'($urandom_range(0, 1));
            m = model(ra, rb, rsub);
            run_op(ra, rb, rsub);
            check_op("rnd", m[W-1:0], m[W], m[W+1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
